// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory stage: word/register types, the stage state enum,
// the LR/SC request bundle and the load-width encodings with their extension helper.
package cpu_types_pkg;

   localparam int WORD_BITS = 32;

   typedef logic [WORD_BITS-1:0] word_t;
   typedef logic [4:0]           regbits_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mem_state_t;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef struct packed {
      logic       ren;
      logic       wen;
      logic       atomic;
      logic [2:0] func3;
      word_t      addr;
      word_t      data;
   } mem_req_t;

   // Little-endian lane select; unknown encodings fall back to the full word.
   function automatic word_t loadExtend(input word_t w, input logic [1:0] off,
                                        input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         LD_LB:   return {{24{b[7]}}, b};
         LD_LBU:  return {24'h0, b};
         LD_LH:   return {{16{h[15]}}, h};
         LD_LHU:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Dcache word port plus the coherence invalidate channel seen by the memory stage.
interface mem_stage_if #(
   parameter int WORD_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] dmemaddr;
   logic [WORD_W-1:0] dmemstore;
   logic              dhit;
   logic [WORD_W-1:0] dmemload;
   logic              ccinv;
   logic [WORD_W-1:0] ccsnoopaddr;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload, ccinv, ccsnoopaddr
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload, ccinv, ccsnoopaddr
   );
endinterface

// File: rtl/mem_resv_reg.sv
// LR/SC reservation: granule register, SC match compare and snoop-invalidate priority.
module mem_resv_reg #(
   parameter int WORD_W    = 32,
   parameter int RESV_GRAN = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] cmpAddr,
   input  logic [WORD_W-1:0] lrAddr,
   input  logic [WORD_W-1:0] snoopAddr,
   input  logic              lrSet,
   input  logic              scClr,
   input  logic              ccinv,
   output logic              resvMatch
);
   localparam int HI = WORD_W - 1;

   logic              resvValid;
   logic [HI:RESV_GRAN] resvAddr;
   logic              invOld;
   logic              invNew;
   logic              unusedLow;

   assign invOld    = ccinv & resvValid & (snoopAddr[HI:RESV_GRAN] == resvAddr);
   assign invNew    = ccinv & (snoopAddr[HI:RESV_GRAN] == lrAddr[HI:RESV_GRAN]);
   // A snoop hitting the granule this cycle already defeats an SC issued alongside it.
   assign resvMatch = resvValid & ~invOld & (cmpAddr[HI:RESV_GRAN] == resvAddr);
   assign unusedLow = ^{cmpAddr[RESV_GRAN-1:0], lrAddr[RESV_GRAN-1:0],
                        snoopAddr[RESV_GRAN-1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         resvValid <= 1'b0;
         resvAddr  <= '0;
      end else if (lrSet) begin
         resvValid <= ~invNew;
         resvAddr  <= lrAddr[HI:RESV_GRAN];
      end else if (scClr || invOld) begin
         resvValid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues dcache word requests, tracks LR/SC, stalls while a miss is open.
// SUBWORD_LOAD_EN enables LB/LH/LBU/LHU extraction; otherwise every load returns the full word.
module mem_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int RESV_GRAN = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              adv,
   input  logic              flush,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic              atomic,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] stdata,
   input  logic [2:0]        func3,
   input  regbits_t          rd,
   input  logic              regWr,
   input  logic              halt,
   input  logic [WORD_W-1:0] alu_res,
   mem_stage_if.master       dc,
   output logic              mem_stall,
   output logic [WORD_W-1:0] wb_data,
   output regbits_t          wb_rd,
   output logic              wb_regWr,
   output logic              wb_halt
);

   mem_state_t        state, stateNext;
   mem_req_t          reqIn, reqQ, cur;
   logic              kill, killed;
   logic              op, scFail, active;
   logic              resvMatch, lrSet, scClr;
   logic [WORD_W-1:0] resQ, result;

   assign reqIn  = '{ren: dREN, wen: dWEN, atomic: atomic, func3: func3,
                     addr: addr, data: stdata};
   assign op     = dREN | dWEN;
   assign killed = kill | flush;
   assign scFail = dWEN & atomic & ~resvMatch;
   // Once a miss is open the request comes from the latched copy, so a flush or a
   // disturbed EX/MEM latch cannot change what the cache sees.
   assign cur    = (state == BUSY) ? reqQ : reqIn;

   always_comb begin
`ifdef SUBWORD_LOAD_EN
      result = loadExtend(dc.dmemload, cur.addr[1:0], cur.func3);
`else
      result = dc.dmemload;
`endif
      if (!cur.ren) result = (cur.wen & cur.atomic) ? '0 : alu_res;
   end

`ifndef SUBWORD_LOAD_EN
   logic unusedF3;
   assign unusedF3 = ^cur.func3;
`endif

   always_comb begin
      stateNext = state;
      active    = 1'b0;
      wb_data   = alu_res;
      case (state)
         IDLE: begin
            if (op && !flush) begin
               if (scFail) begin
                  wb_data = WORD_W'(1);
               end else begin
                  active  = 1'b1;
                  wb_data = result;
                  if (!dc.dhit)  stateNext = BUSY;
                  else if (!adv) stateNext = DONE;
               end
            end
         end
         BUSY: begin
            active  = 1'b1;
            wb_data = result;
            if (dc.dhit) stateNext = adv ? IDLE : DONE;
         end
         DONE: begin
            wb_data = resQ;
            if (adv) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign dc.dmemREN   = active & cur.ren & ~RST;
   assign dc.dmemWEN   = active & cur.wen & ~RST;
   assign dc.dmemaddr  = cur.addr;
   assign dc.dmemstore = cur.data;
   assign mem_stall    = active & ~dc.dhit & ~RST;

   assign wb_rd    = rd;
   assign wb_halt  = halt;
   assign wb_regWr = regWr & ~killed;

   assign lrSet = active & dc.dhit & cur.ren & cur.atomic & ~killed;
   assign scClr = ((state == IDLE) & op & ~flush & scFail)
                | (active & dc.dhit & cur.wen & cur.atomic);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         kill  <= 1'b0;
         resQ  <= '0;
         reqQ  <= '0;
      end else begin
         state <= stateNext;
         // Kill lives as long as the instruction stays in MEM after issue.
         kill  <= (state == IDLE || stateNext == IDLE) ? 1'b0 : killed;
         if (active && dc.dhit) resQ <= result;
         if (state == IDLE && stateNext == BUSY) reqQ <= reqIn;
      end
   end

   mem_resv_reg #(
      .WORD_W    (WORD_W),
      .RESV_GRAN (RESV_GRAN)
   ) uResv (
      .CLK       (CLK),
      .RST       (RST),
      .cmpAddr   (addr),
      .lrAddr    (cur.addr),
      .snoopAddr (dc.ccsnoopaddr),
      .lrSet     (lrSet),
      .scClr     (scClr),
      .ccinv     (dc.ccinv),
      .resvMatch (resvMatch)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a cycle-driven dcache model, one task per scenario.
module tb_mem_stage;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     RST;
   logic     adv, flush, dREN, dWEN, atomic, regWr, halt;
   word_t    addr, stdata, alu_res;
   logic [2:0] func3;
   regbits_t rd;
   logic     mem_stall, wb_regWr, wb_halt;
   word_t    wb_data;
   regbits_t wb_rd;

   mem_stage_if #(.WORD_W(32)) dcif ();

   mem_stage dut (
      .CLK(CLK), .RST(RST), .adv(adv), .flush(flush), .dREN(dREN), .dWEN(dWEN),
      .atomic(atomic), .addr(addr), .stdata(stdata), .func3(func3), .rd(rd),
      .regWr(regWr), .halt(halt), .alu_res(alu_res), .dc(dcif),
      .mem_stall(mem_stall), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_regWr(wb_regWr), .wb_halt(wb_halt)
   );

   always #5 CLK = ~CLK;

   typedef struct { word_t data; logic wr; } exp_t;
   exp_t sb[$];
   int total = 0;
   int bad   = 0;

   task automatic idle();
      dREN = 0; dWEN = 0; atomic = 0; flush = 0; adv = 1; regWr = 0; halt = 0;
      addr = '0; stdata = '0; func3 = LD_LW; alu_res = '0;
      dcif.dhit = 0; dcif.dmemload = '0; dcif.ccinv = 0; dcif.ccsnoopaddr = '0;
   endtask

   // Holds one instruction in MEM for lat+hold+1 cycles; the cache answers at cycle lat.
   task automatic runOp(input logic ren, wen, at, input word_t a, d, ld, alu,
                        input logic [2:0] f3, input int lat, hold, flAt,
                        output word_t obsData, doneData, output logic obsWr,
                        output int stalls, wens, rens);
      stalls = 0; wens = 0; rens = 0; obsData = '0; doneData = '0; obsWr = 1'b0;
      for (int k = 0; k <= lat + hold; k++) begin
         @(posedge CLK); #1;
         dREN = ren; dWEN = wen; atomic = at; addr = a; stdata = d; func3 = f3;
         alu_res = alu; regWr = 1; rd = 5'd9;
         flush = (k == flAt);
         adv = (k >= lat + hold);
         dcif.dmemload = (k == lat) ? ld : 32'hBAD0_BAD0;
         dcif.dhit = 1'b0;
         #1;
         dcif.dhit = (k == lat) && (dcif.dmemREN || dcif.dmemWEN);
         @(negedge CLK);
         stalls += int'(mem_stall);
         wens   += int'(dcif.dmemWEN);
         rens   += int'(dcif.dmemREN);
         if (k == lat) begin obsData = wb_data; obsWr = wb_regWr; end
         if (k == lat + hold) doneData = wb_data;
      end
      @(posedge CLK); #1; idle();
   endtask

   task automatic snoop(input word_t a);
      @(posedge CLK); #1; dcif.ccinv = 1; dcif.ccsnoopaddr = a;
      @(posedge CLK); #1; dcif.ccinv = 0;
   endtask

   task automatic test_reset();
      @(posedge CLK); #1; RST = 1; dREN = 1; dWEN = 1; addr = 32'h40;
      @(negedge CLK);
      total++; if (dcif.dmemREN !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b want=0", dcif.dmemREN); end
      total++; if (dcif.dmemWEN !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b want=0", dcif.dmemWEN); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", mem_stall); end
      @(posedge CLK); #1; RST = 0; idle();
      @(negedge CLK);
      total++; if (dcif.dmemREN !== 1'b0) begin bad++; $display("FAIL post_rst_ren got=%b want=0", dcif.dmemREN); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%b want=0", mem_stall); end
   endtask

   task automatic test_alu();
      word_t od, dd, v; logic ow; int st, wn, rn; exp_t e;
      for (int i = 0; i < 3; i++) begin
         v = $urandom;
         sb.push_back('{v, 1'b1});
         runOp(0, 0, 0, 32'h0, 32'h0, 32'h0, v, LD_LW, 0, 0, -1, od, dd, ow, st, wn, rn);
         e = sb.pop_front();
         total++; if (od !== e.data) begin bad++; $display("FAIL alu_data got=%h want=%h", od, e.data); end
         total++; if (ow !== e.wr) begin bad++; $display("FAIL alu_wr got=%b want=%b", ow, e.wr); end
         total++; if (st != 0) begin bad++; $display("FAIL alu_stall got=%0d want=0", st); end
      end
      halt = 1; #1;
      total++; if (wb_rd !== 5'd9) begin bad++; $display("FAIL wb_rd got=%0d want=9", wb_rd); end
      total++; if (wb_halt !== 1'b1) begin bad++; $display("FAIL wb_halt got=%b want=1", wb_halt); end
      halt = 0;
   endtask

   task automatic test_load();
      word_t od, dd; logic ow; int st, wn, rn; exp_t e;
      sb.push_back('{32'hDEAD_BEEF, 1'b1});
      runOp(1, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h55, LD_LW, 3, 0, -1, od, dd, ow, st, wn, rn);
      e = sb.pop_front();
      total++; if (od !== e.data) begin bad++; $display("FAIL lw_data got=%h want=%h", od, e.data); end
      total++; if (ow !== e.wr) begin bad++; $display("FAIL lw_wr got=%b want=%b", ow, e.wr); end
      total++; if (st != 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=3", st); end
      total++; if (rn != 4) begin bad++; $display("FAIL lw_ren_cycles got=%0d want=4", rn); end
   endtask

   task automatic test_load_hold();
      word_t od, dd; logic ow; int st, wn, rn; exp_t e;
      sb.push_back('{32'hCAFE_F00D, 1'b1});
      runOp(1, 0, 0, 32'h120, 32'h0, 32'hCAFE_F00D, 32'h55, LD_LW, 0, 2, -1, od, dd, ow, st, wn, rn);
      e = sb.pop_front();
      total++; if (od !== e.data) begin bad++; $display("FAIL hold_hit_data got=%h want=%h", od, e.data); end
      total++; if (dd !== e.data) begin bad++; $display("FAIL hold_done_data got=%h want=%h", dd, e.data); end
      total++; if (rn != 1) begin bad++; $display("FAIL hold_ren_cycles got=%0d want=1", rn); end
   endtask

   task automatic test_store_hold();
      word_t od, dd; logic ow; int st, wn, rn;
      runOp(0, 1, 0, 32'h180, 32'h1111_2222, 32'h0, 32'h0, LD_LW, 0, 2, -1, od, dd, ow, st, wn, rn);
      total++; if (wn != 1) begin bad++; $display("FAIL sw_wen_cycles got=%0d want=1", wn); end
      total++; if (st != 0) begin bad++; $display("FAIL sw_stall got=%0d want=0", st); end
   endtask

   task automatic test_flush_busy();
      word_t od, dd; logic ow; int st, wn, rn; exp_t e;
      sb.push_back('{32'h0BAD_CAFE, 1'b0});
      runOp(1, 0, 0, 32'h140, 32'h0, 32'h0BAD_CAFE, 32'h0, LD_LW, 3, 0, 1, od, dd, ow, st, wn, rn);
      e = sb.pop_front();
      total++; if (ow !== e.wr) begin bad++; $display("FAIL flush_wr got=%b want=%b", ow, e.wr); end
      total++; if (rn != 4) begin bad++; $display("FAIL flush_ren_cycles got=%0d want=4", rn); end
      sb.push_back('{32'h0000_0077, 1'b1});
      runOp(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h77, LD_LW, 0, 0, -1, od, dd, ow, st, wn, rn);
      e = sb.pop_front();
      total++; if (ow !== e.wr) begin bad++; $display("FAIL after_flush_wr got=%b want=%b", ow, e.wr); end
   endtask

   // Each row: LR addr, snoop addr (0 = none, 1 = snoop coincides with LR), SC addr.
   task automatic test_lrsc();
      word_t od, dd; logic ow; int st, wn, rn; exp_t e;
      word_t lrA[6]  = '{32'h200, 32'h0,   32'h200, 32'h200, 32'h200, 32'h200};
      word_t snA[6]  = '{32'h0,   32'h0,   32'h200, 32'h300, 32'h0,   32'h1};
      word_t scA[6]  = '{32'h200, 32'h200, 32'h200, 32'h203, 32'h204, 32'h200};
      logic  okv[6]  = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0};
      for (int i = 0; i < 6; i++) begin
         if (lrA[i] != 0) begin
            if (snA[i] == 32'h1) begin dcif.ccinv = 1; dcif.ccsnoopaddr = lrA[i]; end
            sb.push_back('{32'h0000_1234, 1'b1});
            runOp(1, 0, 1, lrA[i], 32'h0, 32'h0000_1234, 32'h0, LD_LW, 1, 0, -1, od, dd, ow, st, wn, rn);
            e = sb.pop_front();
            total++; if (od !== e.data) begin bad++; $display("FAIL lr%0d_data got=%h want=%h", i, od, e.data); end
         end
         if (snA[i] > 32'h1) snoop(snA[i]);
         sb.push_back('{okv[i] ? 32'h0 : 32'h1, 1'b1});
         runOp(0, 1, 1, scA[i], 32'hABCD, 32'h0, 32'h0, LD_LW, 0, 0, -1, od, dd, ow, st, wn, rn);
         e = sb.pop_front();
         total++; if (od !== e.data) begin bad++; $display("FAIL sc%0d_data got=%h want=%h", i, od, e.data); end
         total++; if (wn != int'(okv[i])) begin bad++; $display("FAIL sc%0d_wen got=%0d want=%0d", i, wn, okv[i]); end
      end
   endtask

   task automatic test_rst_busy();
      word_t od, dd; logic ow; int st, wn, rn; exp_t e;
      runOp(1, 0, 1, 32'h300, 32'h0, 32'h5, 32'h0, LD_LW, 0, 0, -1, od, dd, ow, st, wn, rn);
      @(posedge CLK); #1; dREN = 1; addr = 32'h100; regWr = 1; adv = 0;
      @(negedge CLK);
      total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b want=1", mem_stall); end
      @(posedge CLK); #1; RST = 1; idle();
      @(negedge CLK);
      total++; if (dcif.dmemREN !== 1'b0) begin bad++; $display("FAIL rstbusy_ren got=%b want=0", dcif.dmemREN); end
      @(posedge CLK); #1; RST = 0;
      @(negedge CLK);
      total++; if (dcif.dmemREN !== 1'b0) begin bad++; $display("FAIL after_rst_ren got=%b want=0", dcif.dmemREN); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL after_rst_stall got=%b want=0", mem_stall); end
      sb.push_back('{32'h1, 1'b1});
      runOp(0, 1, 1, 32'h300, 32'h9, 32'h0, 32'h0, LD_LW, 0, 0, -1, od, dd, ow, st, wn, rn);
      e = sb.pop_front();
      total++; if (od !== e.data) begin bad++; $display("FAIL rst_sc_data got=%h want=%h", od, e.data); end
      total++; if (wn != 0) begin bad++; $display("FAIL rst_sc_wen got=%0d want=0", wn); end
   endtask

   task automatic test_subword();
      word_t od, dd; logic ow; int st, wn, rn; exp_t e;
`ifdef SUBWORD_LOAD_EN
      word_t      aT[5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
      logic [2:0] fT[5] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW};
      word_t      xT[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF7F, 32'h80FF_FF7F};
`else
      word_t      aT[5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
      logic [2:0] fT[5] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW};
      word_t      xT[5] = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F};
`endif
      for (int i = 0; i < 5; i++) begin
         sb.push_back('{xT[i], 1'b1});
         runOp(1, 0, 0, aT[i], 32'h0, 32'h80FF_FF7F, 32'h0, fT[i], 1, 0, -1, od, dd, ow, st, wn, rn);
         e = sb.pop_front();
         total++; if (od !== e.data) begin bad++; $display("FAIL sub%0d_data got=%h want=%h", i, od, e.data); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1; rd = 5'd0; idle();
      repeat (2) @(posedge CLK);
      test_reset();
      test_alu();
      test_load();
      test_load_hold();
      test_store_hold();
      test_flush_busy();
      test_lrsc();
      test_rst_busy();
      test_subword();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM latch and the MEM/WB latch.
- Consumes the latched EX/MEM outputs and issues word requests to the dcache.
- Manages an LR/SC reservation that is cleared by coherence invalidations.
- Produces writeback data/control and a stall while an access is outstanding.

Parameters:
- WORD_W, 32, data/address width (matches word_t)
- RESV_GRAN, 2, low address bits ignored in reservation compare (word granularity)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- adv  in  1  MEM/WB latch enable this cycle (pipeline advancing)
- flush  in  1  kill instruction currently in MEM
- dREN  in  1  load request from EX/MEM
- dWEN  in  1  store request from EX/MEM
- atomic  in  1  LR (with dREN) / SC (with dWEN)
- addr  in  32  effective address (EX/MEM port_out)
- stdata  in  32  store data (EX/MEM dmemstore)
- func3  in  3  load width/sign select
- rd  in  5  destination register
- regWr  in  1  register write enable
- halt  in  1  halt marker
- alu_res  in  32  non-memory result to forward
- dhit  in  1  dcache access complete
- dmemload  in  32  dcache read data
- ccinv  in  1  coherence invalidate
- ccsnoopaddr  in  32  invalidated address
- dmemREN  out  1  dcache read request
- dmemWEN  out  1  dcache write request
- dmemaddr  out  32  dcache address
- dmemstore  out  32  dcache write data
- mem_stall  out  1  hold PC/IF/ID/EX/MEM latches
- wb_data  out  32  result to MEM/WB
- wb_rd  out  5  destination register
- wb_regWr  out  1  gated write enable (0 when killed)
- wb_halt  out  1  halt passthrough

Behaviour:
- Reset: state IDLE; reservation invalid; kill flag 0; load-data register 0; dmemREN/dmemWEN/mem_stall 0.
- op = dREN|dWEN. sc_fail = dWEN & atomic & ~(resv_valid & addr[31:RESV_GRAN] == resv_addr[31:RESV_GRAN]).
- IDLE:
  - op & flush: no request; wb_regWr 0.
  - op & sc_fail: no request; wb_data = 1; no stall; reservation cleared.
  - op otherwise: drive request combinationally. If dhit: result valid this cycle, mem_stall 0; go to DONE if ~adv, else stay IDLE. If ~dhit: go to BUSY, mem_stall 1.
- BUSY:
  - Request held stable; mem_stall = ~dhit.
  - flush sets the kill flag but does not drop the request; the store/load runs to dhit.
  - On dhit: capture dmemload; go to DONE if ~adv, else IDLE. Kill flag forces wb_regWr 0 and is then cleared.
- DONE:
  - No request driven; wb_data taken from the captured register; mem_stall 0.
  - adv → IDLE. A store is never reissued.
- Results:
  - load: extended dmemload.
  - SC success: wb_data 0 and the write issues.
  - non-memory op: wb_data = alu_res, passes in zero latency.
- Reservation:
  - LR completion sets resv_valid and resv_addr = addr.
  - Any SC completion (success or fail) clears it.
  - ccinv with matching granule clears it in the same cycle. If ccinv and LR completion coincide on the same granule, the invalidate wins.
- RST while in BUSY: abandon immediately at the edge; the cache sees its request drop.

Optional Feature:
- SUBWORD_LOAD_EN defined: func3 selects LB/LH/LW/LBU/LHU. Byte/half chosen by addr[1:0]; sign or zero extended.
- Undefined: all loads are full words; func3 ignored.

Decomposition:
- cpu_types_pkg holds word_t, regbits_t, the mem_state_t enum {IDLE, BUSY, DONE}, and the func3 load encodings.
- One sub-module, mem_resv_reg, holds the reservation register, the match compare and the invalidate priority.

Test Plan:
- LW at 0x100, dhit after 3 cycles, dmemload 0xDEADBEEF → mem_stall 1 for 3 cycles; wb_data 0xDEADBEEF, wb_regWr 1.
- SW with dhit and adv=0 for 2 cycles → exactly one dmemWEN cycle; DONE held; no reissue.
- LR 0x200 then SC 0x200 → dmemWEN asserted, wb_data 0. Repeat with ccinv snoop 0x200 between them → no write, wb_data 1.
- flush during BUSY load → request held until dhit, then wb_regWr 0.
- RST asserted mid-BUSY → next cycle dmemREN 0, state IDLE, reservation invalid.
- With SUBWORD_LOAD_EN: LB at addr 0x103, word 0x80FF_FF7F → wb_data 0xFFFFFF80. LBU → 0x00000080.
